// File: rtl/stb_gen_pkg.sv
// stb_gen_pkg: shared mode encoding for the strobe generator.
package stb_gen_pkg;
    typedef enum logic {
        MODE_GEN   = 1'b0,
        MODE_LEARN = 1'b1
    } mode_e;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser followed by a registered rising-edge detector.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic sig_i,
    output logic edge_o
);
    logic [STAGES-1:0] sync;
    logic              sync_d;
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            sync   <= '0;
            sync_d <= 1'b0;
            edge_o <= 1'b0;
        end else begin
            sync   <= {sync[STAGES-2:0], sig_i};
            sync_d <= sync[STAGES-1];
            edge_o <= sync[STAGES-1] & ~sync_d;
        end
    end
endmodule

// File: rtl/stb_gen.sv
// stb_gen: learns the period of sig_i, then flywheels a phase counter and
// emits stb_o LEAD cycles ahead of each predicted edge; err_o flags bad timing.
module stb_gen
    import stb_gen_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LEAD        = 4,
    parameter int TOL         = 2
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic sig_i,
    input  logic freq_det_i,
    input  logic oe_i,
    output logic stb_o,
    output logic err_o
);
    localparam int W = CNT_W + 2;
    mode_e            mode;
    logic             sig_edge;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_q;
    logic             valid;
    logic             seen_edge;
    logic [W-1:0]     meas;
    logic [W-1:0]     per_w;
    logic             gen;
    logic             cnt_max;
    logic             in_win;
    logic             late;
    logic             short_per;
    logic             stb_cond;
    logic             err_set;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .sig_i  (sig_i),
        .edge_o (sig_edge)
    );

    // Compare in a wider domain so period_q +/- TOL never wraps.
    always_comb begin
        mode      = mode_e'(freq_det_i);
        gen       = mode == MODE_GEN;
        meas      = W'(cnt) + W'(1);
        per_w     = W'(period_q);
        cnt_max   = &cnt;
        in_win    = (meas + W'(TOL) >= per_w) && (meas <= per_w + W'(TOL));
        late      = gen && valid && !sig_edge && (meas > per_w + W'(TOL));
        short_per = per_w < W'(LEAD + 2);
        stb_cond  = gen && valid && !short_per && (per_w == W'(cnt) + W'(LEAD + 1));
        err_set   = gen && (!valid || short_per || late || (sig_edge && !in_win));
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            cnt       <= '0;
            period_q  <= '0;
            valid     <= 1'b0;
            seen_edge <= 1'b0;
            stb_o     <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            cnt   <= (sig_edge || late) ? '0 : cnt_max ? cnt : cnt + 1'b1;
            stb_o <= stb_cond && oe_i;
            err_o <= gen ? (err_o | err_set) : 1'b0;
            if (gen) begin
                seen_edge <= 1'b0;
            end else begin
                if (sig_edge)
                    seen_edge <= 1'b1;
                if (sig_edge && seen_edge)
                    period_q <= cnt + 1'b1;
                if (cnt_max)
                    valid <= 1'b0;
                else if (sig_edge && seen_edge)
                    valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stb_gen.sv
// tb_stb_gen: directed bench; sig_i is driven on falling edges with a 346-cycle nominal period.
module tb_stb_gen;
    localparam int P  = 346;
    localparam int HI = 12;

    logic clk_i = 1'b0;
    logic arst_i;
    logic sig_i;
    logic freq_det_i;
    logic oe_i;
    logic stb_o;
    logic err_o;

    int   n_vec = 0;
    int   n_err = 0;
    int   strobes;
    int   misplaced;
    logic last_err;
    int   jit [6] = '{345, 347, 346, 347, 345, 346};

    stb_gen dut (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .sig_i      (sig_i),
        .freq_det_i (freq_det_i),
        .oe_i       (oe_i),
        .stb_o      (stb_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // In lock, a strobe is observed on the sample just before the sig_i rise (ph 0).
    task automatic step(input logic s, input int ph);
        @(negedge clk_i);
        if (stb_o) begin
            strobes++;
            if (ph != 0) misplaced++;
        end
        last_err = err_o;
        sig_i = s;
    endtask

    task automatic clr();
        strobes   = 0;
        misplaced = 0;
    endtask

    task automatic pulses(input int n, input int p);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < p; j++)
                step(j < HI, j);
    endtask

    task automatic do_reset(input string tag);
        arst_i = 1'b1;
        step(1'b0, 1);
        arst_i = 1'b0;
        chk({tag, "_stb"}, int'(stb_o), 0);
        chk({tag, "_err"}, int'(last_err), 0);
    endtask

    initial begin
        sig_i = 1'b0; freq_det_i = 1'b1; oe_i = 1'b1; arst_i = 1'b0;
        clr();
        do_reset("rst");

        clr(); pulses(4, P);
        chk("learn_stb", strobes, 0);
        chk("learn_err", int'(last_err), 0);

        freq_det_i = 1'b0;
        clr(); pulses(10, P);
        chk("gen_stb", strobes, 10);
        chk("gen_phase", misplaced, 0);
        chk("gen_err", int'(last_err), 0);

        clr();
        for (int i = 0; i < 6; i++) pulses(1, jit[i]);
        chk("jit_stb", strobes, 6);
        chk("jit_err", int'(last_err), 0);

        oe_i = 1'b0;
        clr(); pulses(3, P);
        chk("oe_off_stb", strobes, 0);
        chk("oe_off_err", int'(last_err), 0);
        oe_i = 1'b1;
        clr(); pulses(3, P);
        chk("oe_on_stb", strobes, 3);
        chk("oe_on_phase", misplaced, 0);
        chk("oe_on_err", int'(last_err), 0);

        clr();
        for (int j = 0; j < P; j++) begin
            step(1'b0, j);
            if (j == 6) chk("miss_err_pre", int'(last_err), 0);
            if (j == 7) chk("miss_err_set", int'(last_err), 1);
        end
        pulses(1, P);
        chk("miss_stb", strobes, 2);
        chk("miss_shift", misplaced, 1);
        clr(); pulses(2, P);
        chk("miss_relock_stb", strobes, 2);
        chk("miss_relock_phase", misplaced, 0);
        chk("miss_err_hold", int'(last_err), 1);

        freq_det_i = 1'b1;
        clr(); pulses(3, P);
        chk("relearn_err", int'(last_err), 0);
        chk("relearn_stb", strobes, 0);

        freq_det_i = 1'b0;
        clr(); pulses(1, 200);
        chk("wrong_err_pre", int'(last_err), 0);
        pulses(1, 200);
        chk("wrong_err_set", int'(last_err), 1);

        do_reset("rst_mid");
        clr(); pulses(2, P);
        chk("novalid_stb", strobes, 0);
        chk("novalid_err", int'(last_err), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
